mem_req_master: RTL and testbench

- Initiator-side controller driving one Nmemory port (instruction or data) on behalf of the CPU.
- Accepts a single CPU access request, presents read/write strobes, address and write data to the memory, and tracks the memory's 3-bit state output until completion.
- Returns read data with a one-cycle ack, and holds the CPU stall line high while an access is in flight.
- Enables the multi-cycle/stalling CPU to use the variable-latency memory instead of assuming single-cycle access.

---
 rtl/mem_if_pkg.sv | 16 +
 rtl/mem_req_master.sv | 105 ++++++++++
 tb/tb_mem_req_master.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/mem_if_pkg.sv
// Memory-port handshake encodings shared between the request master and Nmemory.
package mem_if_pkg;

   localparam logic [2:0] MS_IDLE = 3'd0;
   localparam logic [2:0] MS_BUSY = 3'd1;
   localparam logic [2:0] MS_DONE = 3'd2;
   localparam logic [2:0] MS_ERR  = 3'd3;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } state_t;

endpackage

// File: rtl/mem_req_master.sv
// CPU-side master for one Nmemory port: one access at a time, stalls the CPU until ack.
//
// state    | meaning
// ST_IDLE  | waiting for cpu_req; misaligned requests go straight to ST_RESP with err
// ST_ISSUE | strobe, address and write data presented; timeout counter cleared
// ST_WAIT  | strobe held until MS_DONE, MS_ERR or timeout
// ST_RESP  | one-cycle ack (with err if aborted), stall still high
module mem_req_master
   import mem_if_pkg::*;
#(
   parameter int TIMEOUT     = 16,
   parameter bit ALIGN_CHECK = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [31:0] cpu_addr,
   input  logic [31:0] cpu_wdata,
   output logic [31:0] cpu_rdata,
   output logic        cpu_ack,
   output logic        cpu_err,
   output logic        stall,
   output logic        mem_read,
   output logic        mem_write,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic [2:0]  mem_state
);

   localparam int            CW       = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
   localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);

   state_t        state;
   logic [CW-1:0] cnt;
   logic          we_q;

   // mem_addr/mem_wdata double as the latched request so the strobe is visible in ST_ISSUE
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         we_q      <= 1'b0;
         cpu_rdata <= '0;
         cpu_ack   <= 1'b0;
         cpu_err   <= 1'b0;
         stall     <= 1'b0;
         mem_read  <= 1'b0;
         mem_write <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else begin
         cpu_ack <= 1'b0;
         cpu_err <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (cpu_req) begin
                  stall <= 1'b1;
                  if (ALIGN_CHECK && (cpu_addr[1:0] != 2'b00)) begin
                     cpu_ack <= 1'b1;
                     cpu_err <= 1'b1;
                     state   <= ST_RESP;
                  end else begin
                     we_q      <= cpu_we;
                     mem_addr  <= cpu_addr;
                     mem_wdata <= cpu_wdata;
                     mem_read  <= ~cpu_we;
                     mem_write <= cpu_we;
                     state     <= ST_ISSUE;
                  end
               end
            end
            ST_ISSUE: begin
               cnt   <= '0;
               state <= ST_WAIT;
            end
            ST_WAIT: begin
               if (cnt != CNT_MAX) cnt <= cnt + CW'(1);
               // DONE/ERR in the same cycle as the last count win over the timeout
               if (mem_state == MS_DONE) begin
                  if (!we_q) cpu_rdata <= mem_rdata;
                  mem_read  <= 1'b0;
                  mem_write <= 1'b0;
                  cpu_ack   <= 1'b1;
                  state     <= ST_RESP;
               end else if (mem_state == MS_ERR || cnt == CNT_LAST) begin
                  mem_read  <= 1'b0;
                  mem_write <= 1'b0;
                  cpu_ack   <= 1'b1;
                  cpu_err   <= 1'b1;
                  state     <= ST_RESP;
               end
            end
            ST_RESP: begin
               stall <= 1'b0;
               state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_req_master.sv
// Self-checking bench for mem_req_master: directed table, reset abort, randomized vs. latency model.
module tb_mem_req_master;
   import mem_if_pkg::*;

   localparam int TIMEOUT = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cpu_req = 1'b0;
   logic        cpu_we = 1'b0;
   logic [31:0] cpu_addr = '0;
   logic [31:0] cpu_wdata = '0;
   logic [31:0] cpu_rdata;
   logic        cpu_ack, cpu_err, stall;
   logic        mem_read, mem_write;
   logic [31:0] mem_addr, mem_wdata;
   logic [31:0] mem_rdata = '0;
   logic [2:0]  mem_state = MS_IDLE;

   int n_tests = 0;
   int n_fail  = 0;

   // responder: BUSY for resp_at strobe cycles (ISSUE cycle = 0), then resp_code
   int         resp_at = 0;
   logic [2:0] resp_code = MS_DONE;
   int         s_cnt = 0;

   mem_req_master #(.TIMEOUT(TIMEOUT), .ALIGN_CHECK(1'b1)) dut (
      .clk(clk), .rst(rst),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_err(cpu_err), .stall(stall),
      .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_state(mem_state)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (mem_read || mem_write) begin
         mem_state = (s_cnt >= resp_at) ? resp_code : MS_BUSY;
         s_cnt++;
      end else begin
         mem_state = MS_IDLE;
         s_cnt = 0;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // exp_ack: cycle of the ack pulse counted from the accept cycle (0)
   task automatic run_txn(input string tag, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] mdata,
                          input int ra, input logic [2:0] code,
                          input int exp_ack, input logic exp_err, input logic [31:0] exp_rdata);
      int ack_cyc = 0;
      int rd = 0, wr = 0, st = 0, bad = 0, exp_strobe;
      logic got_err = 1'b0;
      logic [31:0] got_rdata = '0;
      @(negedge clk);
      cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
      mem_rdata = mdata; resp_at = ra; resp_code = code;
      for (int c = 1; c <= 40; c++) begin
         @(posedge clk); #1;
         if (mem_read) rd++;
         if (mem_write) wr++;
         if (stall) st++;
         if (mem_read && mem_write) bad++;
         if ((mem_read || mem_write) && (mem_addr !== addr || (we && mem_wdata !== wdata))) bad++;
         if (cpu_ack) begin
            ack_cyc = c; got_err = cpu_err; got_rdata = cpu_rdata;
            break;
         end
      end
      cpu_req = 1'b0;
      exp_strobe = (exp_ack == 1) ? 0 : exp_ack - 1;
      check({tag, ".ack_cycle"}, 32'(ack_cyc), 32'(exp_ack));
      check({tag, ".err"}, {31'd0, got_err}, {31'd0, exp_err});
      check({tag, ".rdata"}, got_rdata, exp_rdata);
      check({tag, ".read_cycles"}, 32'(rd), we ? 32'd0 : 32'(exp_strobe));
      check({tag, ".write_cycles"}, 32'(wr), we ? 32'(exp_strobe) : 32'd0);
      check({tag, ".stall_cycles"}, 32'(st), 32'(exp_ack));
      check({tag, ".strobe_integrity"}, 32'(bad), 32'd0);
      @(posedge clk); #1;
      check({tag, ".after_ack"}, {30'd0, cpu_ack, stall}, 32'd0);
   endtask

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] mdata;
      int          ra;
      logic [2:0]  code;
      int          exp_ack;
      logic        exp_err;
      logic [31:0] exp_rdata;
   } vec_t;

   vec_t vecs[10];

   logic [31:0] model_rdata;
   int          m_ack, m_sr;
   logic        m_err, m_mis, m_we;
   logic [31:0] m_addr, m_wdata, m_mdata;
   logic [2:0]  m_code;
   int          m_ra, sel;

   initial begin
      vecs[0] = '{1'b0, 32'h10, 32'h0,        32'hDEADBEEF, 2,  MS_DONE, 4,  1'b0, 32'hDEADBEEF};
      vecs[1] = '{1'b1, 32'h20, 32'h12345678, 32'hFFFFFFFF, 2,  MS_DONE, 4,  1'b0, 32'hDEADBEEF};
      vecs[2] = '{1'b0, 32'h22, 32'h0,        32'h11111111, 0,  MS_DONE, 1,  1'b1, 32'hDEADBEEF};
      vecs[3] = '{1'b0, 32'h30, 32'h0,        32'h22222222, 0,  MS_BUSY, 18, 1'b1, 32'hDEADBEEF};
      vecs[4] = '{1'b0, 32'h34, 32'h0,        32'h00000055, 3,  MS_ERR,  5,  1'b1, 32'hDEADBEEF};
      vecs[5] = '{1'b0, 32'h38, 32'h0,        32'h33333333, 0,  3'd6,    18, 1'b1, 32'hDEADBEEF};
      vecs[6] = '{1'b0, 32'h3C, 32'h0,        32'hA5A5A5A5, 0,  MS_DONE, 3,  1'b0, 32'hA5A5A5A5};
      vecs[7] = '{1'b0, 32'h40, 32'h0,        32'h00001234, 16, MS_DONE, 18, 1'b0, 32'h00001234};
      vecs[8] = '{1'b0, 32'h44, 32'h0,        32'h00005678, 17, MS_DONE, 18, 1'b1, 32'h00001234};
      vecs[9] = '{1'b1, 32'h03, 32'hCAFE0000, 32'h0,        0,  MS_DONE, 1,  1'b1, 32'h00001234};

      #1;
      check("reset_outputs", {mem_read, mem_write, stall, cpu_ack, cpu_err, 27'd0}, 32'd0);
      check("reset_addr_data", mem_addr | mem_wdata | cpu_rdata, 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      foreach (vecs[i])
         run_txn($sformatf("vec%0d", i), vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].mdata,
                 vecs[i].ra, vecs[i].code, vecs[i].exp_ack, vecs[i].exp_err, vecs[i].exp_rdata);

      // reset in the middle of a read that never completes
      @(negedge clk);
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h50; mem_rdata = 32'h77777777;
      resp_at = 100; resp_code = MS_BUSY;
      repeat (5) @(posedge clk);
      #1;
      check("rst_pre_read", {31'd0, mem_read}, 32'd1);
      #2 rst = 1'b1;
      #1;
      check("rst_async_drop", {28'd0, mem_read, mem_write, stall, cpu_ack}, 32'd0);
      check("rst_rdata", cpu_rdata, 32'd0);
      cpu_req = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
         check("rst_no_ack", {30'd0, cpu_ack, stall}, 32'd0);
      end
      @(negedge clk);
      rst = 1'b0;
      run_txn("post_rst", 1'b0, 32'h54, 32'h0, 32'hCAFEF00D, 1, MS_DONE, 3, 1'b0, 32'hCAFEF00D);
      model_rdata = 32'hCAFEF00D;

      // randomized accesses against an arithmetic latency model
      for (int i = 0; i < 60; i++) begin
         m_we = 1'($urandom_range(0, 1));
         m_addr = $urandom & 32'hFFFF_FFFC;
         if ($urandom_range(0, 7) == 0) m_addr[1:0] = 2'($urandom_range(1, 3));
         m_wdata = $urandom;
         m_mdata = $urandom;
         m_ra = $urandom_range(0, 20);
         sel = $urandom_range(0, 7);
         if (sel <= 3 || sel == 7) m_code = MS_DONE;
         else if (sel == 4) m_code = MS_ERR;
         else if (sel == 5) m_code = MS_BUSY;
         else m_code = 3'($urandom_range(4, 7));

         m_mis = (m_addr[1:0] != 2'b00);
         m_sr = (m_ra < 1) ? 1 : m_ra;
         if (m_mis) begin
            m_ack = 1; m_err = 1'b1;
         end else if ((m_code == MS_DONE || m_code == MS_ERR) && m_sr <= TIMEOUT) begin
            m_ack = m_sr + 2;
            m_err = (m_code == MS_ERR);
            if (m_code == MS_DONE && !m_we) model_rdata = m_mdata;
         end else begin
            m_ack = TIMEOUT + 2; m_err = 1'b1;
         end
         run_txn($sformatf("rnd%0d", i), m_we, m_addr, m_wdata, m_mdata, m_ra, m_code,
                 m_ack, m_err, model_rdata);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
